// File: rtl/cycle_arbiter.sv
// Round-robin arbiter that shares one timed CStart/CEnd bus cycle among NREQ requesters,
// watches the verifier Error flag, and clears it through a one-cycle RECOVER state.
module cycle_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NREQ-1:0]  Req,
  input  logic [NREQ-1:0]  InjErr,
  output logic [NREQ-1:0]  Gnt,
  output logic [NREQ-1:0]  Done,
  output logic [NREQ-1:0]  Fail,
  output logic             CStart,
  output logic             CEnd,
  input  logic             Error,
  output logic             ErrorRst,
  output logic [CNT_W-1:0] FaultCnt,
  output logic [2:0]       dbg_state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_C1      = 3'd2;
  localparam logic [2:0] S_C2      = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [NREQ-1:0]  gnt_q;
  logic             inj_q;
  logic [PTR_W-1:0] ptr;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] ptr_next;
  logic             enter_rec;

  // Handshake: Req[i] is a level the requester holds until it sees Done[i] or Fail[i];
  // the arbiter only looks at Req in IDLE, so later changes never disturb a cycle in flight.

  // Rotating priority search starting at ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
  end

  // Error is only honoured where a fault can be reported: IDLE, C2 and GAP.
  always_comb begin
    enter_rec = 1'b0;
    if (Error) begin
      case (state)
        S_IDLE, S_C2, S_GAP: enter_rec = 1'b1;
        default:             enter_rec = 1'b0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= S_IDLE;
      gnt_q <= '0;
      inj_q <= 1'b0;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Error) begin
            state <= S_RECOVER;
            gnt_q <= '0;
          end else if (win_found) begin
            state <= S_START;
            gnt_q <= ONE_HOT0 << win_idx;
            inj_q <= InjErr[win_idx];
            ptr   <= ptr_next;
          end
        end
        S_START: state <= S_C1;
        S_C1:    state <= S_C2;
        S_C2: begin
          if (Error) state <= S_RECOVER;
          else       state <= S_GAP;
        end
        S_GAP: begin
          gnt_q <= '0;
          if (Error) state <= S_RECOVER;
          else       state <= S_IDLE;
        end
        S_RECOVER: begin
          state <= S_IDLE;
          gnt_q <= '0;
          inj_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          gnt_q <= '0;
          inj_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      FaultCnt <= '0;
    end else if (enter_rec && (FaultCnt != {CNT_W{1'b1}})) begin
      FaultCnt <= FaultCnt + CNT_W'(1);
    end
  end

  // Moore outputs; an injected fault moves CEnd from C2 forward to C1.
  always_comb begin
    Gnt       = gnt_q;
    CStart    = (state == S_START);
    CEnd      = ((state == S_C1) && inj_q) || ((state == S_C2) && !inj_q);
    Done      = (state == S_GAP) ? gnt_q : '0;
    Fail      = (state == S_RECOVER) ? gnt_q : '0;
    ErrorRst  = (state == S_RECOVER);
    dbg_state = state;
  end

endmodule

// File: tb/tb_cycle_arbiter.sv
// Directed bench for cycle_arbiter: transaction-level reference model compared every cycle,
// a grant-order scoreboard, a small timing verifier, and hand-computed literal checks.
module tb_cycle_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic             Clk = 1'b0;
  logic             Rst = 1'b0;
  logic [NREQ-1:0]  Req = '0;
  logic [NREQ-1:0]  InjErr = '0;
  logic [NREQ-1:0]  Gnt, Done, Fail;
  logic             CStart, CEnd, ErrorRst;
  logic             Error;
  logic [CNT_W-1:0] FaultCnt;
  logic [2:0]       dbg_state;

  logic verifier_en = 1'b1;
  logic force_err   = 1'b0;
  logic v_err;
  logic v_active;
  int   v_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [NREQ-1:0] exp_q[$];
  logic            sb_en = 1'b0;

  cycle_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .InjErr(InjErr), .Gnt(Gnt), .Done(Done), .Fail(Fail),
    .CStart(CStart), .CEnd(CEnd), .Error(Error), .ErrorRst(ErrorRst), .FaultCnt(FaultCnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stand-in verifier: CEnd must come exactly two cycles after CStart; ErrorRst clears.
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v_err    <= 1'b0;
      v_active <= 1'b0;
      v_cnt    <= 0;
    end else begin
      if (ErrorRst) v_err <= 1'b0;
      else if (CEnd && (!v_active || v_cnt != 1)) v_err <= 1'b1;
      if (CStart) begin
        v_active <= 1'b1;
        v_cnt    <= 0;
      end else if (v_active) begin
        v_cnt <= v_cnt + 1;
        if (CEnd) v_active <= 1'b0;
      end
    end
  end
  assign Error = verifier_en ? v_err : force_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is "busy" with a phase count since its CStart.
  typedef struct {
    logic            busy;
    logic            rec;
    int              phase;
    logic [NREQ-1:0] gnt;
    logic            inj;
    int              ptr;
    int              cnt;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.busy = 1'b0; s.rec = 1'b0; s.phase = 0; s.gnt = '0; s.inj = 1'b0; s.ptr = 0; s.cnt = 0;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, logic [NREQ-1:0] req, logic [NREQ-1:0] inj_in,
                                     logic err);
    mstate_t n;
    logic    enter;
    logic    found;
    int      c;
    n = s; enter = 1'b0; found = 1'b0;
    if (s.rec) begin
      n.rec = 1'b0; n.gnt = '0; n.inj = 1'b0;
    end else if (!s.busy) begin
      if (err) enter = 1'b1;
      else begin
        for (int k = 0; k < NREQ; k++) begin
          c = (s.ptr + k) % NREQ;
          if (!found && req[c[1:0]]) begin
            found = 1'b1;
            n.busy = 1'b1; n.phase = 0;
            n.gnt = 4'b0001 << c; n.inj = inj_in[c[1:0]];
            n.ptr = (c + 1) % NREQ;
          end
        end
      end
    end else if (s.phase < 2) begin
      n.phase = s.phase + 1;
    end else if (s.phase == 2) begin
      if (err) begin n.busy = 1'b0; enter = 1'b1; end
      else n.phase = 3;
    end else begin
      n.busy = 1'b0; n.gnt = '0;
      if (err) enter = 1'b1;
    end
    if (enter) begin
      n.rec = 1'b1;
      if (s.cnt < CMAX) n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  function automatic logic [22:0] m_out(mstate_t s);
    logic            cs, ce;
    logic [NREQ-1:0] d, f;
    cs = s.busy && (s.phase == 0);
    ce = s.busy && (s.phase == (s.inj ? 1 : 2));
    d  = (s.busy && s.phase == 3) ? s.gnt : '0;
    f  = s.rec ? s.gnt : '0;
    return {s.gnt, d, f, cs, ce, s.rec, 8'(s.cnt)};
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) m <= m_reset();
    else      m <= m_step(m, Req, InjErr, Error);
  end

  // per-cycle compare against the model
  always @(negedge Clk) begin
    check("cycle_cmp", 32'({Gnt, Done, Fail, CStart, CEnd, ErrorRst, FaultCnt}), 32'(m_out(m)));
  end

  // scoreboard: grant order checked at each CStart while enabled
  always @(negedge Clk) begin
    if (sb_en && CStart) begin
      if (exp_q.size() == 0) check("rr_extra_grant", 32'(Gnt), 32'(0));
      else check("rr_grant", 32'(Gnt), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic reset_dut();
    @(negedge Clk);
    Rst = 1'b0; Req = '0; InjErr = '0; force_err = 1'b0; verifier_en = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wait_cstart(input string name);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!CStart && n < 40);
    check(name, 32'(CStart), 32'(1));
  endtask

  initial begin
    int prev;
    // 1: reset values and a single legal transaction
    reset_dut();
    check("rst_gnt", 32'(Gnt), 32'(0));
    check("rst_cstart", 32'(CStart), 32'(0));
    check("rst_faultcnt", 32'(FaultCnt), 32'(0));
    Req = 4'b0001;
    wait_cstart("t1_cstart_timeout");
    check("t1_gnt", 32'(Gnt), 32'h1);
    @(negedge Clk); check("t1_cend_c1", 32'(CEnd), 32'(0));
    @(negedge Clk); check("t1_cend_c2", 32'(CEnd), 32'(1));
    @(negedge Clk); check("t1_done", 32'(Done), 32'h1);
    Req = 4'b0000;
    @(negedge Clk); check("t1_done_pulse", 32'(Done), 32'h0);
    check("t1_faultcnt", 32'(FaultCnt), 32'(0));

    // 2: all requesting -> strict rotation, period 5
    reset_dut();
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    sb_en = 1'b1;
    Req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_cstart("t2_cstart_timeout");
      if (i > 0) check("t2_period", 32'(cyc - prev), 32'(5));
      prev = cyc;
    end
    Req = 4'b0000;
    repeat (6) @(negedge Clk);
    sb_en = 1'b0;
    check("t2_sb_empty", 32'(exp_q.size()), 32'(0));

    // 3: injected early CEnd caught by the verifier
    reset_dut();
    Req = 4'b0100; InjErr = 4'b0100;
    wait_cstart("t3_cstart_timeout");
    check("t3_gnt", 32'(Gnt), 32'h4);
    InjErr = 4'b0000;
    @(negedge Clk); check("t3_cend_early", 32'(CEnd), 32'(1));
    check("t3_err_t1", 32'(Error), 32'(0));
    @(negedge Clk); check("t3_err_t2", 32'(Error), 32'(1));
    check("t3_cend_t2", 32'(CEnd), 32'(0));
    @(negedge Clk); check("t3_errrst", 32'(ErrorRst), 32'(1));
    check("t3_fail", 32'(Fail), 32'h4);
    check("t3_faultcnt", 32'(FaultCnt), 32'(1));
    check("t3_no_done", 32'(Done), 32'h0);
    Req = 4'b0000;
    @(negedge Clk); check("t3_err_cleared", 32'(Error), 32'(0));
    check("t3_gnt_clr", 32'(Gnt), 32'h0);

    // 4: reset during C2 drops outputs at once; pointer restarts at 0
    reset_dut();
    Req = 4'b0001;
    wait_cstart("t4_cstart_timeout");
    @(negedge Clk);
    @(negedge Clk); check("t4_cend_c2", 32'(CEnd), 32'(1));
    #2 Rst = 1'b0;
    #1;
    check("t4_async_cend", 32'(CEnd), 32'(0));
    check("t4_async_gnt", 32'(Gnt), 32'h0);
    @(negedge Clk); check("t4_no_done", 32'(Done), 32'h0);
    @(negedge Clk);
    Req = 4'b0011;
    Rst = 1'b1;
    wait_cstart("t4_restart_timeout");
    check("t4_restart_gnt", 32'(Gnt), 32'h1);
    repeat (3) @(negedge Clk);
    check("t4_done", 32'(Done), 32'h1);
    Req = 4'b0000;
    repeat (3) @(negedge Clk);

    // 5: Error with nothing granted, then held until FaultCnt saturates
    reset_dut();
    verifier_en = 1'b0;
    force_err = 1'b1;
    @(negedge Clk);
    check("t5_errrst", 32'(ErrorRst), 32'(1));
    check("t5_fail_zero", 32'(Fail), 32'h0);
    check("t5_faultcnt1", 32'(FaultCnt), 32'(1));
    repeat (2) @(negedge Clk);
    check("t5_faultcnt2", 32'(FaultCnt), 32'(2));
    repeat (540) @(negedge Clk);
    check("t5_saturate", 32'(FaultCnt), 32'(255));
    force_err = 1'b0;
    repeat (3) @(negedge Clk);
    check("t5_hold", 32'(FaultCnt), 32'(255));
    check("t5_errrst_off", 32'(ErrorRst), 32'(0));

    // 6: Req[0] dropped mid-cycle still completes; next grant goes to requester 1
    reset_dut();
    Req = 4'b0011;
    wait_cstart("t6_cstart_timeout");
    check("t6_gnt0", 32'(Gnt), 32'h1);
    @(negedge Clk); Req = 4'b0010;
    repeat (2) @(negedge Clk);
    check("t6_done0", 32'(Done), 32'h1);
    wait_cstart("t6_cstart2_timeout");
    check("t6_gnt1", 32'(Gnt), 32'h2);
    repeat (3) @(negedge Clk);
    check("t6_done1", 32'(Done), 32'h2);
    Req = 4'b0000;
    repeat (3) @(negedge Clk);

    // 7: Error seen only during START and C1 is ignored
    reset_dut();
    verifier_en = 1'b0;
    Req = 4'b1000;
    wait_cstart("t7_cstart_timeout");
    force_err = 1'b1;
    repeat (2) @(negedge Clk);
    force_err = 1'b0;
    @(negedge Clk);
    check("t7_done", 32'(Done), 32'h8);
    check("t7_no_errrst", 32'(ErrorRst), 32'(0));
    check("t7_faultcnt", 32'(FaultCnt), 32'(0));
    Req = 4'b0000;
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
